uart_tx_buffered: RTL and testbench

//  UART transmitter with an internal byte FIFO; drives the board's serial TX pin from the CPU output path.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_buffered.sv | 134 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and timing helpers for the buffered UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int bit_period(input int clk_per_half_bit);
        return 2 * clk_per_half_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - single-clock byte FIFO with registered full/empty/count
module uart_tx_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wdata,
    input  logic          wr,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;
    logic [AW:0]   count_next;

    // Flags are registered, so a byte written this cycle is not visible to rd yet.
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_V);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 UART transmitter fed by a byte FIFO; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 30,
    parameter int FIFO_AW          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sdata,
    input  logic               wr_en,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               tx_busy,
    output logic               txd
);

    localparam int BIT_CYC = bit_period(CLK_PER_HALF_BIT);
    localparam int BAUD_W  = $clog2(BIT_CYC);
    localparam int BCNT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_BITS - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud;
    logic [BCNT_W-1:0] bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        head;
    logic              bit_end;
    logic              pop;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    uart_tx_fifo #(
        .AW(FIFO_AW),
        .DW(8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (sdata),
        .wr    (wr_en),
        .rd    (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bit_end = (baud == BAUD_LAST);
    // Reloading straight from STOP keeps back-to-back frames free of idle gaps.
    assign pop = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

    // txd and tx_busy follow the state one cycle later, so every bit keeps its full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tx_busy <= (state != IDLE);
            baud    <= bit_end ? '0 : baud + 1'b1;
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift   <= head;
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        par     <= ^head;
`endif
                        state   <= START;
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    txd <= shift[0];
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    txd <= par;
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= head;
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            par     <= ^head;
`endif
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered; define UART_TX_PARITY_EN to cover the parity build
module tb_uart_tx_buffered;

    localparam int H = 30;
    localparam int AW = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = 2 * H * FRAME_BITS;

    logic          clk;
    logic          rst;
    logic [7:0]    sdata;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          tx_busy;
    logic          txd;

    int            checks;
    int            errors;
    int            cyc;
    int            gen;
    logic          mon_busy;
    logic [7:0]    sb[$];
    int            starts[$];
    logic          last_par;

    uart_tx_buffered #(
        .CLK_PER_HALF_BIT(H),
        .FIFO_AW(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sdata   (sdata),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; the byte is presented to the next rising edge.
    task automatic put(input logic [7:0] b);
        sdata = b;
        wr_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    // Receiver model: decodes frames at mid-bit and checks them against the scoreboard.
    initial begin : monitor
        int         g;
        int         s;
        logic [7:0] b;
        logic [7:0] exp;
        logic       st;
        logic       stp;
`ifdef UART_TX_PARITY_EN
        logic       pb;
`endif
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                mon_busy = 1'b1;
                g = gen;
                s = cyc;
                repeat (H) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (2 * H) @(negedge clk);
                    b[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (2 * H) @(negedge clk);
                pb = txd;
`endif
                repeat (2 * H) @(negedge clk);
                stp = txd;
                if (g == gen) begin
                    starts.push_back(s);
                    check("start_bit", st, 0);
                    check("stop_bit", stp, 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", pb, ^b);
                    last_par = pb;
`endif
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none (cycle %0d)", b, cyc);
                    end else begin
                        exp = sb.pop_front();
                        check("rx_byte", b, exp);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        int n;
        int bad;
        checks   = 0;
        errors   = 0;
        gen      = 0;
        last_par = 1'b0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        sdata    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_full", full, 0);
        check("reset_empty", empty, 1);
        check("reset_count", count, 0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || empty !== 1'b1 || count !== '0 || tx_busy !== 1'b0) bad++;
        end
        check("idle_1000", bad, 0);

        // Single byte latency, then a burst that fills the FIFO while AA is on the wire.
        starts.delete();
        k = cyc + 1;
        sb.push_back(8'hAA);
        put(8'hAA);
        wr_en = 1'b0;
        @(negedge clk);
        check("pop_k1_txd", txd, 1);
        check("pop_k1_empty", empty, 1);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(i));
            put(8'(i));
            if (i == 14) check("full_after_15", full, 0);
        end
        check("full_after_16", full, 1);
        check("count_after_16", count, 16);
        put(8'hFF);
        check("dropped_17th", count, 16);

        // Hold a write until the STOP->START pop; it must still be rejected.
        sdata = 8'hEE;
        wr_en = 1'b1;
        n = 0;
        while (count === 5'd16 && n < FRAME_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0;
        check("write_at_pop_count", count, 15);
        check("write_at_pop_full", full, 0);

        drain("burst_drain", 18 * FRAME_CYC);
        check("burst_frames", starts.size(), 17);
        if (starts.size() > 0) check("first_start_k2", starts[0], k + 2);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != FRAME_CYC) bad++;
        end
        check("burst_no_gap", bad, 0);

        // Reset in the middle of frame 2 of 4.
        k = cyc + 1;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        put(8'h11);
        put(8'h22);
        put(8'h33);
        put(8'h44);
        wr_en = 1'b0;
        while (cyc < k + FRAME_CYC + 301) @(negedge clk);
        check("frames_before_reset", sb.size(), 3);
        rst = 1'b1;
        gen++;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midreset_txd", txd, 1);
        check("midreset_count", count, 0);
        check("midreset_empty", empty, 1);
        check("midreset_busy", tx_busy, 0);
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("no_frames_after_reset", bad, 0);
        sb.push_back(8'h5A);
        put(8'h5A);
        wr_en = 1'b0;
        drain("after_reset_drain", 2 * FRAME_CYC);

`ifdef UART_TX_PARITY_EN
        sb.push_back(8'h07);
        put(8'h07);
        wr_en = 1'b0;
        drain("parity_drain", 2 * FRAME_CYC);
        check("parity_07", last_par, 1);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
